// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV64M multiply/divide sequencer for the execute stage.
// Runs one radix-2 step per cycle (shift-add multiply, restoring divide),
// then one fix-up cycle for signs and word sign-extension. The result is
// held until the consumer takes it.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready only while idle)
//   op, is_word         0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU (5-7 illegal); W form
//   a, b                rs1 / rs2 operand values
//   flush               synchronous kill of any in-flight op
//   out_valid/out_ready result handshake; result stable while not taken
//   busy                high whenever the sequencer is not idle
module mdu_seq #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned HW = XLEN / 2;
  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_DIV  = 3'd1,
    OP_DIVU = 3'd2,
    OP_REM  = 3'd3,
    OP_REMU = 3'd4
  } op_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      op_q, op_d;
  logic            word_q, word_d;
  logic            spec_q, spec_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] acc_q, acc_d;     // product / partial remainder / special value
  logic [XLEN-1:0] x_q, x_d;         // multiplicand / dividend-quotient shift register
  logic [XLEN-1:0] y_q, y_d;         // multiplier / divisor magnitude
  logic [XLEN-1:0] result_q, result_d;

  logic            signed_op, is_mul, illegal, div_zero, overflow, special;
  logic            a_neg, b_neg, ge;
  logic [XLEN-1:0] a_eff, b_eff, a_mag, b_mag, min_neg, spec_val, rem_sub, fix_val;
  logic [XLEN:0]   rem_sh;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    word_d   = word_q;
    spec_d   = spec_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;

    // Operand preparation for a request presented in IDLE.
    signed_op = (op == OP_DIV) || (op == OP_REM);
    is_mul    = (op == OP_MUL);
    illegal   = (op > OP_REMU);
    a_eff     = is_word ? {{HW{signed_op & a[HW-1]}}, a[HW-1:0]} : a;
    b_eff     = is_word ? {{HW{signed_op & b[HW-1]}}, b[HW-1:0]} : b;
    a_neg     = signed_op & a_eff[XLEN-1];
    b_neg     = signed_op & b_eff[XLEN-1];
    a_mag     = a_neg ? -a_eff : a_eff;
    b_mag     = b_neg ? -b_eff : b_eff;
    min_neg   = is_word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero  = !is_mul && !illegal && (b_eff == '0);
    overflow  = signed_op && (a_eff == min_neg) && (b_eff == '1);
    special   = illegal || div_zero || overflow;

    spec_val = '0;
    if (div_zero)
      spec_val = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a_eff;
    else if (overflow)
      spec_val = (op == OP_DIV) ? a_eff : '0;

    // Restoring divide step: shift the next dividend bit into the remainder.
    rem_sh  = {acc_q, x_q[XLEN-1]};
    ge      = (rem_sh >= {1'b0, y_q});
    rem_sub = rem_sh[XLEN-1:0] - y_q;

    fix_val = acc_q;
    if (!spec_q) begin
      if ((op_q == OP_DIV) || (op_q == OP_DIVU))
        fix_val = qneg_q ? -x_q : x_q;
      else if ((op_q == OP_REM) || (op_q == OP_REMU))
        fix_val = rneg_q ? -acc_q : acc_q;
    end

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            // Special cases spend a single suppressed RUN cycle so that
            // they share the RUN -> FIX -> DONE path.
            state_d = S_RUN;
            count_d = special ? CW'(1) : (is_word ? CW'(HW) : CW'(XLEN));
            op_d    = op;
            word_d  = is_word;
            spec_d  = special;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            acc_d   = special ? spec_val : '0;
            if (is_mul) begin
              x_d = a_eff;
              y_d = b_eff;
            end else begin
              // Word dividends are left-aligned so every op shifts from bit XLEN-1.
              x_d = is_word ? (a_mag << HW) : a_mag;
              y_d = b_mag;
            end
          end
        end
        S_RUN: begin
          if (!spec_q) begin
            if (op_q == OP_MUL) begin
              acc_d = acc_q + (y_q[0] ? x_q : '0);
              x_d   = x_q << 1;
              y_d   = y_q >> 1;
            end else begin
              acc_d = ge ? rem_sub : rem_sh[XLEN-1:0];
              x_d   = {x_q[XLEN-2:0], ge};
            end
          end
          if (count_q == CW'(1))
            state_d = S_FIX;
          else
            count_d = count_q - CW'(1);
        end
        S_FIX: begin
          result_d = word_q ? {{HW{fix_val[HW-1]}}, fix_val[HW-1:0]} : fix_val;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (out_ready)
            state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      spec_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      word_q   <= word_d;
      spec_q   <= spec_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: bench for mdu_seq. Directed vector table, randomized ops
// against an arithmetic reference model, and hand-written sequences for
// backpressure, flush and mid-operation reset.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, is_word, flush, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [63:0] a, b, result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_seq #(.XLEN(64)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .is_word(is_word), .a(a), .b(b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: RV64M results straight from the arithmetic definitions.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic w,
                                            input logic [63:0] x, input logic [63:0] y);
    longint      sx, sy;
    int          sx32, sy32;
    logic [31:0] x32, y32, r32;
    logic [63:0] r;
    r = '0;
    if (o > 3'd4) return '0;
    if (!w) begin
      sx = x; sy = y;
      case (o)
        3'd0: r = x * y;
        3'd1: if (y == 0) r = '1;
              else if (x == 64'h8000_0000_0000_0000 && y == '1) r = x;
              else r = 64'(sx / sy);
        3'd2: r = (y == 0) ? '1 : x / y;
        3'd3: if (y == 0) r = x;
              else if (x == 64'h8000_0000_0000_0000 && y == '1) r = '0;
              else r = 64'(sx % sy);
        default: r = (y == 0) ? x : x % y;
      endcase
    end else begin
      x32 = x[31:0]; y32 = y[31:0];
      sx32 = x32; sy32 = y32;
      case (o)
        3'd0: r32 = x32 * y32;
        3'd1: if (y32 == 0) r32 = '1;
              else if (x32 == 32'h8000_0000 && y32 == '1) r32 = x32;
              else r32 = 32'(sx32 / sy32);
        3'd2: r32 = (y32 == 0) ? '1 : x32 / y32;
        3'd3: if (y32 == 0) r32 = x32;
              else if (x32 == 32'h8000_0000 && y32 == '1) r32 = '0;
              else r32 = 32'(sx32 % sy32);
        default: r32 = (y32 == 0) ? x32 : x32 % y32;
      endcase
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic w,
                                 input logic [63:0] x, input logic [63:0] y);
    logic bz, ovf;
    if (o > 3'd4) return 2;
    bz  = w ? (y[31:0] == 0) : (y == 0);
    ovf = (o == 3'd1 || o == 3'd3) &&
          (w ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
             : (x == 64'h8000_0000_0000_0000 && y == '1));
    if ((o != 3'd0 && bz) || ovf) return 2;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 9));
      5: return -64'($urandom_range(1, 9));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns #1 after the accept edge.
  task automatic start_op(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
    in_valid = 1'b1; op = o; is_word = w; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " idle"}, 64'({in_ready, busy, out_valid}), 64'b100);
  endtask

  task automatic run_vec(input string nm, input logic [2:0] o, input logic w, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] exp, input int exp_lat);
    int   lat;
    logic bok;
    start_op(o, w, x, y);
    wait_valid(lat, bok);
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " busy"}, 64'(bok), 64'd1);
    chk({nm, " result"}, result, exp);
    consume(nm);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    logic bok, stable, seen;
    logic [63:0] held, ra, rb;
    logic [2:0]  ro;
    logic        rw;

    vecs[0]  = '{3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65};
    vecs[1]  = '{3'd1, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    vecs[2]  = '{3'd3, 1'b0, 64'd7, 64'd0, 64'd7, 2};
    vecs[3]  = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2};
    vecs[4]  = '{3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2};
    vecs[5]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[6]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[7]  = '{3'd2, 1'b1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[8]  = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[9]  = '{3'd5, 1'b0, 64'd123, 64'd4, 64'd0, 2};
    vecs[10] = '{3'd4, 1'b1, 64'h8000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0000, 2};
    vecs[11] = '{3'd1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2};
    vecs[12] = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 65};
    vecs[13] = '{3'd4, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    vecs[14] = '{3'd3, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'hDEAD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[15] = '{3'd1, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};

    rst_n = 1'b0; in_valid = 1'b0; op = '0; is_word = 1'b0; a = '0; b = '0;
    flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset outputs", 64'({in_ready, busy, out_valid}), 64'b100);
    chk("reset result", result, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b,
              vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 120; i++) begin
      ro = 3'($urandom_range(0, 4));
      rw = 1'($urandom_range(0, 1));
      ra = rand_val();
      rb = rand_val();
      run_vec($sformatf("rand%0d op%0d w%0d", i, ro, rw), ro, rw, ra, rb,
              ref_model(ro, rw, ra, rb), ref_lat(ro, rw, ra, rb));
    end

    // Backpressure: hold the result for 10 cycles, then release with a new request waiting.
    start_op(3'd0, 1'b0, 64'd3, 64'd5);
    wait_valid(lat, bok);
    chk("bp result", result, 64'd15);
    held = result;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== held) stable = 1'b0;
    end
    chk("bp hold", 64'(stable), 64'd1);
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd2; is_word = 1'b0; a = 64'd100; b = 64'd7;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release idle", 64'({in_ready, busy, out_valid}), 64'b100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp reaccept busy", 64'(busy), 64'd1);
    wait_valid(lat, bok);
    chk("bp second latency", 64'(lat), 64'd65);
    chk("bp second result", result, 64'd14);
    consume("bp second");

    // Flush in RUN around cycle 20.
    start_op(3'd0, 1'b0, 64'd11, 64'd13);
    repeat (19) begin @(posedge clk); #1; end
    chk("flush run busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush run idle", 64'({in_ready, busy, out_valid}), 64'b100);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1'b1;
    end
    chk("flush run no output", 64'(seen), 64'd0);

    // Flush in IDLE blocks acceptance.
    in_valid = 1'b1; flush = 1'b1; op = 3'd1; a = 64'd9; b = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush idle no accept", 64'({in_ready, busy, out_valid}), 64'b100);

    // Flush together with out_ready in DONE.
    start_op(3'd1, 1'b0, 64'd7, 64'd0);
    wait_valid(lat, bok);
    chk("flush done valid", 64'(out_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush done idle", 64'({in_ready, busy, out_valid}), 64'b100);

    // Reset mid-RUN: outputs return to reset values at once, nothing afterwards.
    start_op(3'd1, 1'b0, 64'd1000, 64'd3);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("reset mid outputs", 64'({in_ready, busy, out_valid}), 64'b100);
    chk("reset mid result", result, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1'b1;
    end
    chk("reset mid no output", 64'(seen), 64'd0);

    run_vec("after reset", 3'd1, 1'b0, 64'd1000, 64'd3, 64'd333, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
